pc_fetch_ctrl: RTL

Instruction-fetch sequencer directly upstream of the decode stage. Owns the 12-bit program counter and drives a synchronous-read instruction memory. Registers each returned instruction with its PC onto the decode-stage inputs `pc`, `ins` and `nop`. Honours a decode stall, takes branch/jump redirects from later stages, inserts bubbles, and keeps a count of instructions handed to decode.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/pc_fetch_ctrl.sv | 89 ++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared CPU widths, bubble encoding and decode-side bundle type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    localparam logic [DATA_W-1:0] NOP_INS = 32'h0;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] ins;
        logic              nop;
    } fetch_out_t;

endpackage

`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
// ============================================================================
// Module      : pc_fetch_ctrl
// Description : Program counter / instruction-fetch sequencer feeding decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_fetch_ctrl #(
    parameter int                ADDR_W   = cpu_pkg::ADDR_W,
    parameter int                DATA_W   = cpu_pkg::DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] ins,
    output logic              nop,
    output logic [31:0]       fetch_count
);

    logic [ADDR_W-1:0] r_fetch_pc;
    logic              r_inflight;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_ins;
    logic              r_nop;
    logic [31:0]       r_fetch_count;

    logic [ADDR_W-1:0] w_fetch_pc_inc;
    logic              w_consume;

    assign w_fetch_pc_inc = r_fetch_pc + ADDR_W'(1);
    assign w_consume      = !r_nop && !stall && !redirect;

    // A stalled fetch simply re-reads fetch_pc, so rdata stays valid without a skid buffer.
    always_comb begin
        imem_addr = w_fetch_pc_inc;
        if (redirect) begin
            imem_addr = redirect_pc;
        end else if (!r_inflight) begin
            imem_addr = r_fetch_pc;
        end else if (stall) begin
            imem_addr = r_fetch_pc;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_pc          <= RESET_PC;
            r_ins         <= DATA_W'(cpu_pkg::NOP_INS);
            r_nop         <= 1'b1;
            r_fetch_count <= 32'd0;
        end else begin
            if (redirect) begin
                // Decode holds a wrong-path instruction; kill it even when stalled.
                r_fetch_pc <= redirect_pc;
                r_inflight <= 1'b1;
                r_ins      <= DATA_W'(cpu_pkg::NOP_INS);
                r_nop      <= 1'b1;
            end else if (!r_inflight) begin
                r_inflight <= 1'b1;
                r_nop      <= 1'b1;
            end else if (!stall) begin
                r_pc       <= r_fetch_pc;
                r_ins      <= imem_rdata;
                r_nop      <= 1'b0;
                r_fetch_pc <= w_fetch_pc_inc;
            end

            if (w_consume) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
        end
    end

    assign pc          = r_pc;
    assign ins         = r_ins;
    assign nop         = r_nop;
    assign fetch_count = r_fetch_count;

endmodule

`default_nettype wire
